// File: rtl/counter_ctrl.sv
// Parametrised up/down counter with prescaler, wrap/saturate limit handling,
// terminal-count, wrap-pulse and sticky-overflow status. `COUNTER_SNAPSHOT_EN adds a snapshot register.
module counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
`ifdef COUNTER_SNAPSHOT_EN
    input  logic             snapshot,
    output logic [WIDTH-1:0] snap_count,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             overflow
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             wrap_q, wrap_d;
    logic             overflow_q, overflow_d;
    logic             step;
    logic             at_limit;

    // A step at the limit is attempted in the current direction; saturate mode only suppresses the move.
    assign at_limit = up_down ? (count_q == MAX_C) : (count_q == '0);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        count_d    = count_q;
        ps_d       = ps_q;
        wrap_d     = 1'b0;
        overflow_d = overflow_q;
        step       = 1'b0;

        if (clear) begin
            count_d    = '0;
            ps_d       = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d = (load_value > MAX_C) ? MAX_C : load_value;
            ps_d    = '0;
        end else if (enable) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                step = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end

        if (step) begin
            if (at_limit) begin
                wrap_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = up_down ? '0 : MAX_C;
                end
            end else if (up_down) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end

        overflow_d = overflow_d | wrap_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            ps_q       <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            count_q    <= count_d;
            ps_q       <= ps_d;
            wrap_q     <= wrap_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef COUNTER_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_q, snap_d;

    // Captures the value count takes at this edge, so a clear in the same cycle snapshots zero.
    assign snap_d = snapshot ? count_d : snap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_count = snap_q;
`endif

    assign count    = count_q;
    assign tc       = up_down ? (count_q == MAX_C) : (count_q == '0);
    assign wrap     = wrap_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: four parameter sets driven in parallel, each checked against
// a modular-arithmetic reference model; directed scenarios followed by random stimulus.
module tb_counter_ctrl;

    localparam int N = 4;
    localparam int MAXV [N] = '{15, 9, 5, 12};
    localparam int PSC  [N] = '{1, 1, 1, 3};
    localparam int SAT  [N] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, clear, load, up_down;
    logic [3:0] load_value;
    logic [3:0] count_w [N];
    logic       tc_w [N];
    logic       wrap_w [N];
    logic       ovf_w [N];
`ifdef COUNTER_SNAPSHOT_EN
    logic       snapshot;
    logic [3:0] snap_w [N];
`endif

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
`ifdef COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_w[0]),
`endif
        .count(count_w[0]), .tc(tc_w[0]), .wrap(wrap_w[0]), .overflow(ovf_w[0]));

    counter_ctrl #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
`ifdef COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_w[1]),
`endif
        .count(count_w[1]), .tc(tc_w[1]), .wrap(wrap_w[1]), .overflow(ovf_w[1]));

    counter_ctrl #(.WIDTH(4), .MAX_VAL(5), .PRESCALE(1), .SATURATE(1)) u_dut2 (
        .clk(clk), .reset(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
`ifdef COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_w[2]),
`endif
        .count(count_w[2]), .tc(tc_w[2]), .wrap(wrap_w[2]), .overflow(ovf_w[2]));

    counter_ctrl #(.WIDTH(4), .MAX_VAL(12), .PRESCALE(3), .SATURATE(0)) u_dut3 (
        .clk(clk), .reset(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_value(load_value), .up_down(up_down),
`ifdef COUNTER_SNAPSHOT_EN
        .snapshot(snapshot), .snap_count(snap_w[3]),
`endif
        .count(count_w[3]), .tc(tc_w[3]), .wrap(wrap_w[3]), .overflow(ovf_w[3]));

    typedef struct {
        int         inst;
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       ovf;
        logic [3:0] snap;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: count, prescale phase, last wrap, sticky overflow, snapshot.
    int   m_cnt  [N];
    int   m_ps   [N];
    bit   m_wrap [N];
    bit   m_ovf  [N];
    int   m_snap [N];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[u%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit en, input bit cl, input bit ld,
                              input int lv, input bit ud, input bit sn);
        for (int i = 0; i < N; i++) begin
            if (!rn) begin
                m_cnt[i] = 0; m_ps[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; m_snap[i] = 0;
            end else begin
                m_wrap[i] = 0;
                if (cl) begin
                    m_cnt[i] = 0; m_ps[i] = 0; m_ovf[i] = 0;
                end else if (ld) begin
                    m_cnt[i] = (lv > MAXV[i]) ? MAXV[i] : lv;
                    m_ps[i]  = 0;
                end else if (en) begin
                    m_ps[i] = (m_ps[i] + 1) % PSC[i];
                    if (m_ps[i] == 0) begin
                        bit lim;
                        lim       = ud ? (m_cnt[i] == MAXV[i]) : (m_cnt[i] == 0);
                        m_wrap[i] = lim;
                        if (!(lim && SAT[i] != 0))
                            m_cnt[i] = (m_cnt[i] + (ud ? 1 : MAXV[i])) % (MAXV[i] + 1);
                    end
                end
                m_ovf[i] = m_ovf[i] | m_wrap[i];
                if (sn) m_snap[i] = m_cnt[i];
            end
        end
    endtask

    task automatic push_expect(input bit ud);
        for (int i = 0; i < N; i++) begin
            bit t;
            t = ud ? (m_cnt[i] == MAXV[i]) : (m_cnt[i] == 0);
            exp_q.push_back('{i, 4'(m_cnt[i]), t, m_wrap[i], m_ovf[i], 4'(m_snap[i])});
        end
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input bit rn, input bit en, input bit cl, input bit ld,
                       input logic [3:0] lv, input bit ud, input bit sn);
        @(posedge clk);
        #1;
        rst_n = rn; enable = en; clear = cl; load = ld; load_value = lv; up_down = ud;
`ifdef COUNTER_SNAPSHOT_EN
        snapshot = sn;
`endif
        if (!rn) model_edge(1'b0, en, cl, ld, int'(lv), ud, sn);
        push_expect(ud);
        model_edge(rn, en, cl, ld, int'(lv), ud, sn);
    endtask

    task automatic hold(input bit ud);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, ud, 1'b0);
    endtask

    // Reset asserted between edges: outputs must clear before any further clock edge.
    task automatic async_reset(input int pre_u3);
        @(posedge clk);
        #1;
        check("pre_reset_count", 3, 32'(count_w[3]), 32'(pre_u3));
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("async_count", i, 32'(count_w[i]), 0);
            check("async_wrap", i, 32'(wrap_w[i]), 0);
            check("async_ovf", i, 32'(ovf_w[i]), 0);
`ifdef COUNTER_SNAPSHOT_EN
            check("async_snap", i, 32'(snap_w[i]), 0);
`endif
        end
        model_edge(1'b0, enable, clear, load, int'(load_value), up_down, 1'b0);
        push_expect(up_down);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", e.inst, 32'(count_w[e.inst]), 32'(e.cnt));
                check("tc", e.inst, 32'(tc_w[e.inst]), 32'(e.tc));
                check("wrap", e.inst, 32'(wrap_w[e.inst]), 32'(e.wrap));
                check("overflow", e.inst, 32'(ovf_w[e.inst]), 32'(e.ovf));
`ifdef COUNTER_SNAPSHOT_EN
                check("snap_count", e.inst, 32'(snap_w[e.inst]), 32'(e.snap));
`endif
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0; up_down = 1'b1;
`ifdef COUNTER_SNAPSHOT_EN
        snapshot = 1'b0;
`endif
        model_edge(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        // Up count from reset: 17 enabled edges.
        repeat (17) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hold(1'b1);
        check("up17_count", 0, 32'(count_w[0]), 1);
        check("up17_ovf", 0, 32'(ovf_w[0]), 1);
        check("up17_count", 1, 32'(count_w[1]), 7);
        check("up17_count", 2, 32'(count_w[2]), 5);
        check("up17_count", 3, 32'(count_w[3]), 5);
        check("up17_ovf", 3, 32'(ovf_w[3]), 0);

        // Load 2 then count down through zero.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        hold(1'b0);
        check("down_count", 0, 32'(count_w[0]), 14);
        check("down_count", 1, 32'(count_w[1]), 8);
        check("down_count", 2, 32'(count_w[2]), 0);
        check("down_count", 3, 32'(count_w[3]), 1);

        // Clear beats load; load clamps to the modulus limit.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        hold(1'b1);
        for (int i = 0; i < N; i++) begin
            check("clr_ld_count", i, 32'(count_w[i]), 0);
            check("clr_ld_ovf", i, 32'(ovf_w[i]), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
        hold(1'b1);
        check("clamp_count", 0, 32'(count_w[0]), 15);
        check("clamp_count", 1, 32'(count_w[1]), 9);
        check("clamp_tc", 1, 32'(tc_w[1]), 1);
        check("clamp_count", 3, 32'(count_w[3]), 12);

        // Prescaler: a 2-cycle enable gap delays the next step by 2 cycles.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hold(1'b1);
        check("ps_first", 3, 32'(count_w[3]), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        hold(1'b1);
        hold(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("ps_gap_before", 3, 32'(count_w[3]), 1);
        hold(1'b1);
        check("ps_gap_after", 3, 32'(count_w[3]), 2);

        // Reach count 7 on the prescaled counter one enable into its next step, then reset.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (22) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        async_reset(7);
        hold(1'b1);

`ifdef COUNTER_SNAPSHOT_EN
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        hold(1'b1);
        check("snap_3to4", 0, 32'(snap_w[0]), 4);
`endif

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
                $urandom_range(9) == 0, 4'($urandom), 1'($urandom), $urandom_range(3) == 0);
        end
        hold(1'b1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drain", 0, 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
